osd_layer_mixer: RTL and testbench

//  Multi-layer OSD video mixer: background YUV plus C_CH_N character/fuchi overlay channels.
//  Per-channel colour, enable, fuchi-mask and field-blink control.

---
 rtl/osd_layer_mixer_if.sv | 20 ++
 rtl/osd_layer_mixer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_osd_layer_mixer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_layer_mixer_if.sv
// osd_layer_mixer_if: configuration write bus of the OSD layer mixer.
// The master drives one write per clock edge with CFG_WE high.
// CFG_As: [4:2] channel, [1:0] register (0 CHAR_Y, 1 FUCHI_Y, 2 CTRL, 3 ALPHA).
interface osd_layer_mixer_if;
    logic       CFG_WE;
    logic [4:0] CFG_As;
    logic [7:0] CFG_WDs;

    modport master (
        output CFG_WE,
        output CFG_As,
        output CFG_WDs
    );

    modport slave (
        input CFG_WE,
        input CFG_As,
        input CFG_WDs
    );
endinterface

// File: rtl/osd_layer_mixer.sv
// osd_layer_mixer: background YUV plus C_CH_N character/fuchi overlay channels.
// Channel 0 has the highest priority. Timing strobes travel with the pixels.
// Optional build macro: OSD_ALPHA_EN adds a per-channel alpha blend stage,
// which raises the pixel latency from 2 to 3 enabled cycles.
module osd_layer_mixer #(
    parameter int C_CH_N    = 4,
    parameter int C_DAT_W   = 8,
    parameter int C_BLINK_W = 5
) (
    input  logic               CK_i,
    input  logic               AR_i,
    input  logic               CK_EE_i,
    input  logic               XVD_i,
    input  logic [C_DAT_W-1:0] YYs_i,
    input  logic [C_DAT_W-1:0] UUs_i,
    input  logic [C_DAT_W-1:0] VVs_i,
    input  logic               BLANK_i,
    input  logic               XSYNC_i,
    input  logic               BURST_i,
    input  logic [C_CH_N-1:0]  CHARs_i,
    input  logic [C_CH_N-1:0]  FUCHIs_i,
    input  logic               OSD_ON_i,
    osd_layer_mixer_if.slave   cfg,
    output logic [C_DAT_W-1:0] YYs_o,
    output logic [C_DAT_W-1:0] UUs_o,
    output logic [C_DAT_W-1:0] VVs_o,
    output logic               BLANK_o,
    output logic               XSYNC_o,
    output logic               BURST_o,
    output logic               HIT_o
);

    // Per-channel configuration. CTRL: bit0 enable, bit1 blink, bit2 fuchi mask.
    logic [7:0] char_y_q  [C_CH_N];
    logic [7:0] fuchi_y_q [C_CH_N];
    logic [2:0] ctrl_q    [C_CH_N];
`ifdef OSD_ALPHA_EN
    logic [7:0] alpha_q   [C_CH_N];
`endif

    logic [C_BLINK_W-1:0] fld_ctr_q;
    logic [C_BLINK_W-1:0] fld_ctr_d;
    logic                 blink_off;

    // Stage 1: registered background, timing and per-channel hit/colour snapshot.
    logic [C_CH_N-1:0]  hit_d;
    logic [7:0]         col_d    [C_CH_N];
    logic [C_CH_N-1:0]  s1_hit_q;
    logic [7:0]         s1_col_q [C_CH_N];
`ifdef OSD_ALPHA_EN
    logic [7:0]         s1_alpha_q [C_CH_N];
`endif
    logic [C_DAT_W-1:0] s1_y_q;
    logic [C_DAT_W-1:0] s1_u_q;
    logic [C_DAT_W-1:0] s1_v_q;
    logic               s1_blank_q;
    logic               s1_xsync_q;
    logic               s1_burst_q;
    logic               s1_osd_on_q;

    // Stage 2: priority select.
    logic [7:0]         win_col_d;
    logic [C_DAT_W-1:0] ovl_y_d;
    logic               show_d;
`ifdef OSD_ALPHA_EN
    logic [7:0]         win_alpha_d;
`endif

    // Output registers.
    logic [C_DAT_W-1:0] y_q;
    logic [C_DAT_W-1:0] u_q;
    logic [C_DAT_W-1:0] v_q;
    logic               blank_q;
    logic               xsync_q;
    logic               burst_q;
    logic               hit_q;

    // Config writes land on any clock edge; channels beyond C_CH_N match no slot.
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            for (int i = 0; i < C_CH_N; i++) begin
                char_y_q[i]  <= 8'hFF;
                fuchi_y_q[i] <= 8'h00;
                ctrl_q[i]    <= 3'b001;
`ifdef OSD_ALPHA_EN
                alpha_q[i]   <= 8'hFF;
`endif
            end
        end else if (cfg.CFG_WE) begin
            for (int i = 0; i < C_CH_N; i++) begin
                if (cfg.CFG_As[4:2] == 3'(i)) begin
                    case (cfg.CFG_As[1:0])
                        2'd0:    char_y_q[i]  <= cfg.CFG_WDs;
                        2'd1:    fuchi_y_q[i] <= cfg.CFG_WDs;
                        2'd2:    ctrl_q[i]    <= cfg.CFG_WDs[2:0];
`ifdef OSD_ALPHA_EN
                        2'd3:    alpha_q[i]   <= cfg.CFG_WDs;
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    assign fld_ctr_d = fld_ctr_q + C_BLINK_W'(1);
    assign blink_off = fld_ctr_q[C_BLINK_W-1];

    // Field counter: one step per field-start pulse, wraps naturally.
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            fld_ctr_q <= '0;
        end else if (CK_EE_i && !XVD_i) begin
            fld_ctr_q <= fld_ctr_d;
        end
    end

    // Per-channel visibility and hit; the colour is snapshotted here so a
    // config write after sampling cannot alter a pixel already in flight.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < C_CH_N; i++) begin
            col_d[i] = CHARs_i[i] ? char_y_q[i] : fuchi_y_q[i];
            hit_d[i] = ctrl_q[i][0] & ~(ctrl_q[i][1] & blink_off)
                     & (CHARs_i[i] | (FUCHIs_i[i] & ~ctrl_q[i][2]));
        end
    end

    // Stage 1 register.
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            s1_hit_q    <= '0;
            s1_y_q      <= '0;
            s1_u_q      <= '0;
            s1_v_q      <= '0;
            s1_blank_q  <= 1'b1;
            s1_xsync_q  <= 1'b1;
            s1_burst_q  <= 1'b0;
            s1_osd_on_q <= 1'b0;
            for (int i = 0; i < C_CH_N; i++) begin
                s1_col_q[i]   <= '0;
`ifdef OSD_ALPHA_EN
                s1_alpha_q[i] <= '0;
`endif
            end
        end else if (CK_EE_i) begin
            s1_hit_q    <= hit_d;
            s1_y_q      <= YYs_i;
            s1_u_q      <= UUs_i;
            s1_v_q      <= VVs_i;
            s1_blank_q  <= BLANK_i;
            s1_xsync_q  <= XSYNC_i;
            s1_burst_q  <= BURST_i;
            s1_osd_on_q <= OSD_ON_i;
            for (int i = 0; i < C_CH_N; i++) begin
                s1_col_q[i]   <= col_d[i];
`ifdef OSD_ALPHA_EN
                s1_alpha_q[i] <= alpha_q[i];
`endif
            end
        end
    end

    // Lowest-index hitting channel wins: scan downwards so it is assigned last.
    always_comb begin
        win_col_d = '0;
`ifdef OSD_ALPHA_EN
        win_alpha_d = '0;
`endif
        for (int i = C_CH_N - 1; i >= 0; i--) begin
            if (s1_hit_q[i]) begin
                win_col_d = s1_col_q[i];
`ifdef OSD_ALPHA_EN
                win_alpha_d = s1_alpha_q[i];
`endif
            end
        end
        ovl_y_d = C_DAT_W'(win_col_d);
        show_d  = (|s1_hit_q) & s1_osd_on_q & ~s1_blank_q;
    end

`ifdef OSD_ALPHA_EN
    localparam int PW = C_DAT_W + 10;

    logic [C_DAT_W-1:0]   s2_y_q;
    logic [C_DAT_W-1:0]   s2_u_q;
    logic [C_DAT_W-1:0]   s2_v_q;
    logic [C_DAT_W-1:0]   s2_ovl_q;
    logic [8:0]           s2_w_q;
    logic                 s2_hit_q;
    logic                 s2_blank_q;
    logic                 s2_xsync_q;
    logic                 s2_burst_q;
    logic [8:0]           win_w_d;
    logic [8:0]           w_inv;
    logic [PW-1:0]        y_sum;
    logic signed [PW-1:0] u_sum;
    logic signed [PW-1:0] v_sum;
    logic [C_DAT_W-1:0]   y_mix;
    logic [C_DAT_W-1:0]   u_mix;
    logic [C_DAT_W-1:0]   v_mix;

    // Alpha 0xFF maps to 256 so a fully opaque overlay is exact.
    assign win_w_d = {1'b0, win_alpha_d} + {8'd0, win_alpha_d[7]};

    // Stage 2 register: winner and background held for the blend.
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            s2_y_q     <= '0;
            s2_u_q     <= '0;
            s2_v_q     <= '0;
            s2_ovl_q   <= '0;
            s2_w_q     <= '0;
            s2_hit_q   <= 1'b0;
            s2_blank_q <= 1'b1;
            s2_xsync_q <= 1'b1;
            s2_burst_q <= 1'b0;
        end else if (CK_EE_i) begin
            s2_y_q     <= s1_y_q;
            s2_u_q     <= s1_u_q;
            s2_v_q     <= s1_v_q;
            s2_ovl_q   <= ovl_y_d;
            s2_w_q     <= win_w_d;
            s2_hit_q   <= show_d;
            s2_blank_q <= s1_blank_q;
            s2_xsync_q <= s1_xsync_q;
            s2_burst_q <= s1_burst_q;
        end
    end

    // Blend; overlay chroma is zero so only the background term survives in U/V.
    always_comb begin
        w_inv = 9'd256 - s2_w_q;
        y_sum = PW'(s2_w_q) * PW'(s2_ovl_q) + PW'(w_inv) * PW'(s2_y_q);
        u_sum = PW'($signed({1'b0, w_inv})) * PW'($signed(s2_u_q));
        v_sum = PW'($signed({1'b0, w_inv})) * PW'($signed(s2_v_q));
        y_mix = C_DAT_W'(y_sum >> 8);
        u_mix = C_DAT_W'(u_sum >>> 8);
        v_mix = C_DAT_W'(v_sum >>> 8);
    end

    // Output register: blended overlay pixels, untouched background otherwise.
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            blank_q <= 1'b1;
            xsync_q <= 1'b1;
            burst_q <= 1'b0;
            hit_q   <= 1'b0;
        end else if (CK_EE_i) begin
            y_q     <= s2_hit_q ? y_mix : s2_y_q;
            u_q     <= s2_hit_q ? u_mix : s2_u_q;
            v_q     <= s2_hit_q ? v_mix : s2_v_q;
            blank_q <= s2_blank_q;
            xsync_q <= s2_xsync_q;
            burst_q <= s2_burst_q;
            hit_q   <= s2_hit_q;
        end
    end
`else
    // Output register: opaque overlay with zero chroma, else background.
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            blank_q <= 1'b1;
            xsync_q <= 1'b1;
            burst_q <= 1'b0;
            hit_q   <= 1'b0;
        end else if (CK_EE_i) begin
            y_q     <= show_d ? ovl_y_d : s1_y_q;
            u_q     <= show_d ? '0 : s1_u_q;
            v_q     <= show_d ? '0 : s1_v_q;
            blank_q <= s1_blank_q;
            xsync_q <= s1_xsync_q;
            burst_q <= s1_burst_q;
            hit_q   <= show_d;
        end
    end
`endif

    assign YYs_o   = y_q;
    assign UUs_o   = u_q;
    assign VVs_o   = v_q;
    assign BLANK_o = blank_q;
    assign XSYNC_o = xsync_q;
    assign BURST_o = burst_q;
    assign HIT_o   = hit_q;

endmodule

// File: tb/tb_osd_layer_mixer.sv
// tb_osd_layer_mixer: directed scenarios plus randomized traffic, checked every
// cycle against a pixel-queue reference model of the mixer.
module tb_osd_layer_mixer;
    localparam int CH_N = 4;
    localparam int BW   = 2;
`ifdef OSD_ALPHA_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
        logic       blank;
        logic       xsync;
        logic       burst;
        logic       hit;
    } px_t;

    logic       CK = 1'b0;
    logic       AR = 1'b1;
    logic       EE = 1'b0;
    logic       XVD = 1'b1;
    logic [7:0] yi = 8'h00, ui = 8'h00, vi = 8'h00;
    logic       blank_i = 1'b1, xsync_i = 1'b1, burst_i = 1'b0;
    logic [3:0] chars = 4'h0, fuchis = 4'h0;
    logic       osd_on = 1'b0;

    logic [7:0] yo, uo, vo;
    logic       blank_o, xsync_o, burst_o, hit_o;

    osd_layer_mixer_if cfg_if();

    osd_layer_mixer #(.C_CH_N(CH_N), .C_DAT_W(8), .C_BLINK_W(BW)) dut (
        .CK_i(CK), .AR_i(AR), .CK_EE_i(EE), .XVD_i(XVD),
        .YYs_i(yi), .UUs_i(ui), .VVs_i(vi),
        .BLANK_i(blank_i), .XSYNC_i(xsync_i), .BURST_i(burst_i),
        .CHARs_i(chars), .FUCHIs_i(fuchis), .OSD_ON_i(osd_on),
        .cfg(cfg_if),
        .YYs_o(yo), .UUs_o(uo), .VVs_o(vo),
        .BLANK_o(blank_o), .XSYNC_o(xsync_o), .BURST_o(burst_o), .HIT_o(hit_o)
    );

    always #5 CK = ~CK;

    int  errors = 0;
    int  checks = 0;
    bit  check_en = 1'b0;

    // Reference model state.
    px_t        m_q[$];
    px_t        m_exp;
    int         m_ctr;
    logic [7:0] m_chy [8];
    logic [7:0] m_fuy [8];
    logic [7:0] m_alpha [8];
    logic [2:0] m_ctrl [8];

    function automatic px_t idle_px();
        px_t p;
        p = '0;
        p.blank = 1'b1;
        p.xsync = 1'b1;
        return p;
    endfunction

    // What the mixer must emit for the pixel currently on the inputs.
    function automatic px_t model_px();
        px_t p;
        int  win;
        int  ovl;
        bit  boff;
`ifdef OSD_ALPHA_EN
        int  w;
`endif
        p       = '0;
        p.y     = yi;
        p.u     = ui;
        p.v     = vi;
        p.blank = blank_i;
        p.xsync = xsync_i;
        p.burst = burst_i;
        boff    = ((m_ctr >> (BW - 1)) & 1) == 1;
        win     = -1;
        for (int i = 0; i < CH_N; i++) begin
            if (win < 0 && m_ctrl[i][0] && !(m_ctrl[i][1] && boff) &&
                (chars[i] || (fuchis[i] && !m_ctrl[i][2])))
                win = i;
        end
        if (win >= 0 && osd_on && !blank_i) begin
            ovl   = chars[win] ? int'(m_chy[win]) : int'(m_fuy[win]);
            p.hit = 1'b1;
`ifdef OSD_ALPHA_EN
            w   = int'(m_alpha[win]) + ((m_alpha[win] >= 8'h80) ? 1 : 0);
            p.y = 8'((w * ovl + (256 - w) * int'(yi)) >>> 8);
            p.u = 8'(((256 - w) * int'($signed(ui))) >>> 8);
            p.v = 8'(((256 - w) * int'($signed(vi))) >>> 8);
`else
            p.y = 8'(ovl);
            p.u = 8'h00;
            p.v = 8'h00;
`endif
        end
        return p;
    endfunction

    // Model update: pixels enter a LAT-deep queue; config writes land after sampling.
    always @(posedge CK or posedge AR) begin
        if (AR) begin
            m_ctr = 0;
            for (int i = 0; i < 8; i++) begin
                m_chy[i]   = 8'hFF;
                m_fuy[i]   = 8'h00;
                m_ctrl[i]  = 3'b001;
                m_alpha[i] = 8'hFF;
            end
            m_q.delete();
            for (int k = 0; k < LAT - 1; k++) m_q.push_back(idle_px());
            m_exp = idle_px();
        end else begin
            if (EE) begin
                m_q.push_back(model_px());
                m_exp = m_q.pop_front();
                if (!XVD) m_ctr = (m_ctr + 1) % (1 << BW);
            end
            if (cfg_if.CFG_WE && int'(cfg_if.CFG_As[4:2]) < CH_N) begin
                case (cfg_if.CFG_As[1:0])
                    2'd0: m_chy[cfg_if.CFG_As[4:2]]   = cfg_if.CFG_WDs;
                    2'd1: m_fuy[cfg_if.CFG_As[4:2]]   = cfg_if.CFG_WDs;
                    2'd2: m_ctrl[cfg_if.CFG_As[4:2]]  = cfg_if.CFG_WDs[2:0];
                    default: m_alpha[cfg_if.CFG_As[4:2]] = cfg_if.CFG_WDs;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge CK) begin
        if (check_en) begin
            checks++;
            if ({yo, uo, vo, blank_o, xsync_o, burst_o, hit_o} !== m_exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t got y=%h u=%h v=%h bl=%b xs=%b bu=%b hit=%b want y=%h u=%h v=%h bl=%b xs=%b bu=%b hit=%b",
                         $time, yo, uo, vo, blank_o, xsync_o, burst_o, hit_o,
                         m_exp.y, m_exp.u, m_exp.v, m_exp.blank, m_exp.xsync, m_exp.burst, m_exp.hit);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge CK);
        #2;
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] r, input logic [7:0] d, input logic ee);
        cfg_if.CFG_WE  = 1'b1;
        cfg_if.CFG_As  = {ch, r};
        cfg_if.CFG_WDs = d;
        EE = ee;
        clk1();
        cfg_if.CFG_WE = 1'b0;
    endtask

    initial begin
        cfg_if.CFG_WE  = 1'b0;
        cfg_if.CFG_As  = 5'd0;
        cfg_if.CFG_WDs = 8'd0;
        @(posedge CK);
        #1 check_en = 1'b1;
        repeat (2) clk1();
        chk("rst_y", yo, 8'h00);
        chk("rst_blank_xsync_burst", 8'({blank_o, xsync_o, burst_o}), 8'b110);
        chk("rst_hit", 8'(hit_o), 8'h00);
        AR = 1'b0;
        EE = 1'b1; osd_on = 1'b1; blank_i = 1'b0;
        yi = 8'h20; ui = 8'h08; vi = 8'hF8;

        // Priority: ch0 fuchi beats ch1/ch2 chars; disabling ch0 hands over to ch1.
        wr(3'd0, 2'd1, 8'h10, 1'b0);
        wr(3'd1, 2'd0, 8'hFF, 1'b0);
        chars = 4'b0110; fuchis = 4'b0001; EE = 1'b1;
        repeat (LAT) clk1();
        chk("prio_y", yo, 8'h10);
        chk("prio_u", uo, 8'h00);
        chk("prio_hit", 8'(hit_o), 8'h01);
        wr(3'd0, 2'd2, 8'h00, 1'b1);
        repeat (LAT - 1) clk1();
        chk("ctrl_wr_old", yo, 8'h10);
        clk1();
        chk("ctrl_wr_new", yo, 8'hFF);
        wr(3'd0, 2'd2, 8'h01, 1'b0);

        // Config hazard on CHAR_Y, and writes to a nonexistent channel.
        chars = 4'b0001; fuchis = 4'b0000; EE = 1'b1;
        repeat (LAT) clk1();
        chk("char_default", yo, 8'hFF);
        wr(3'd0, 2'd0, 8'h33, 1'b1);
        repeat (LAT - 1) clk1();
        chk("hazard_old", yo, 8'hFF);
        clk1();
        chk("hazard_new", yo, 8'h33);
        wr(3'd7, 2'd0, 8'h77, 1'b1);
        wr(3'd4, 2'd0, 8'h66, 1'b1);
        repeat (LAT) clk1();
        chk("ignored_ch", yo, 8'h33);

        // Passthrough and timing-strobe delay.
        osd_on = 1'b0; chars = 4'b1111;
        yi = 8'h55; ui = 8'h12; vi = 8'hF0;
        repeat (LAT) clk1();
        chk("pass_y", yo, 8'h55);
        chk("pass_u", uo, 8'h12);
        chk("pass_v", vo, 8'hF0);
        chk("pass_hit", 8'(hit_o), 8'h00);
        blank_i = 1'b1; xsync_i = 1'b0; burst_i = 1'b1;
        clk1();
        blank_i = 1'b0; xsync_i = 1'b1; burst_i = 1'b0;
        repeat (LAT - 2) clk1();
        chk("strobe_not_yet", 8'({blank_o, xsync_o, burst_o}), 8'b010);
        EE = 1'b0;
        clk1();
        chk("strobe_hold", 8'({blank_o, xsync_o, burst_o}), 8'b010);
        EE = 1'b1;
        clk1();
        chk("strobe_arrive", 8'({blank_o, xsync_o, burst_o}), 8'b101);
        clk1();
        chk("strobe_leave", 8'({blank_o, xsync_o, burst_o}), 8'b010);

        // Blink: on for fields 0,1, off for 2,3, repeating after the wrap.
        osd_on = 1'b1; chars = 4'b0001;
        wr(3'd0, 2'd2, 8'h03, 1'b0);
        EE = 1'b1;
        for (int f = 0; f < 8; f++) begin
            XVD = 1'b1;
            repeat (LAT + 1) clk1();
            chk($sformatf("blink_f%0d", f), 8'(hit_o), ((f % 4) < 2) ? 8'h01 : 8'h00);
            XVD = 1'b0;
            clk1();
        end
        XVD = 1'b1;
        wr(3'd0, 2'd2, 8'h01, 1'b0);

        // Alpha register: blends when built in, ignored otherwise.
        wr(3'd0, 2'd0, 8'hFF, 1'b0);
        yi = 8'h00; ui = 8'h40; vi = 8'hC0; EE = 1'b1;
`ifdef OSD_ALPHA_EN
        wr(3'd0, 2'd3, 8'hFF, 1'b0);
        EE = 1'b1;
        repeat (LAT) clk1();
        chk("alpha_ff_y", yo, 8'hFF);
        chk("alpha_ff_u", uo, 8'h00);
        wr(3'd0, 2'd3, 8'h7F, 1'b0);
        EE = 1'b1;
        repeat (LAT) clk1();
        chk("alpha_7f_y", yo, 8'h7E);
        chk("alpha_7f_u", uo, 8'h20);
        chk("alpha_7f_v", vo, 8'hDF);
`else
        wr(3'd0, 2'd3, 8'h00, 1'b0);
        EE = 1'b1;
        repeat (LAT) clk1();
        chk("alpha_ignored_y", yo, 8'hFF);
        chk("alpha_ignored_u", uo, 8'h00);
`endif

        // Randomized traffic including writes to every channel slot.
        for (int n = 0; n < 3000; n++) begin
            EE      = ($urandom_range(3) != 0);
            XVD     = ($urandom_range(19) != 0);
            yi      = 8'($urandom);
            ui      = 8'($urandom);
            vi      = 8'($urandom);
            blank_i = ($urandom_range(7) == 0);
            xsync_i = ($urandom_range(7) != 0);
            burst_i = ($urandom_range(7) == 0);
            chars   = 4'($urandom);
            fuchis  = 4'($urandom);
            osd_on  = ($urandom_range(9) != 0);
            cfg_if.CFG_WE  = ($urandom_range(4) == 0);
            cfg_if.CFG_As  = 5'($urandom);
            cfg_if.CFG_WDs = 8'($urandom);
            clk1();
        end
        cfg_if.CFG_WE = 1'b0;

        // Reset mid-line with an overlay showing.
        wr(3'd0, 2'd2, 8'h01, 1'b1);
        wr(3'd0, 2'd0, 8'hFF, 1'b1);
`ifdef OSD_ALPHA_EN
        wr(3'd0, 2'd3, 8'hFF, 1'b1);
`endif
        osd_on = 1'b1; blank_i = 1'b0; chars = 4'b0001; EE = 1'b1;
        repeat (LAT) clk1();
        chk("pre_rst_hit", 8'(hit_o), 8'h01);
        AR = 1'b1;
        #1;
        chk("midrst_y", yo, 8'h00);
        chk("midrst_uv", 8'(uo | vo), 8'h00);
        chk("midrst_strobes", 8'({blank_o, xsync_o, burst_o, hit_o}), 8'b1100);
        clk1();
        AR = 1'b0;
        for (int k = 0; k < 400; k++) begin
            EE      = ((k % 4) == 0);
            yi      = 8'($urandom);
            ui      = 8'($urandom);
            vi      = 8'($urandom);
            chars   = 4'($urandom);
            fuchis  = 4'($urandom);
            blank_i = ($urandom_range(7) == 0);
            XVD     = ($urandom_range(9) != 0);
            clk1();
        end

        EE = 1'b1;
        repeat (LAT + 1) clk1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
